// File: rtl/rq_req_arbiter_x8.sv
// rq_req_arbiter_x8
//
// Packet-level round-robin arbiter that shares one 256-bit requester-request
// (RQ) stream between NUM_REQ upstream requesters. A grant is held from the
// first beat to the tlast beat of a packet, so beats of different packets
// never interleave. Non-posted (NP) packets consume a credit on their first
// accepted beat. Credits are returned by np_done pulses. NP requesters are
// held off while all MAX_NP credits are in use. Posted requesters keep being
// served.
//
// Parameters:
//   DATA_WIDTH  beat width in bits
//   KEEP_WIDTH  dword keep width (DATA_WIDTH / 32)
//   NUM_REQ     number of requester ports (2..8)
//   MAX_NP      maximum outstanding NP requests (1..255)
//
// Ports:
//   user_clk, user_reset_n   clock, asynchronous active-low reset
//   req_t*                   per-requester AXI-S inputs; requester i at slice i
//   req_tready               per-requester ready; only the granted port sees tready
//   s_axis_rq_t*             merged stream to the RQ adapter
//   np_done                  one-cycle pulse that releases one NP credit
//   np_outstanding           current NP credit count
//   grant                    one-hot active grant; zero while idle
module rq_req_arbiter_x8 #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned MAX_NP     = 32
) (
  input  logic                             user_clk,
  input  logic                             user_reset_n,

  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]    req_tkeep,
  input  logic [NUM_REQ*4-1:0]             req_tuser,
  input  logic [NUM_REQ-1:0]               req_tlast,
  input  logic [NUM_REQ-1:0]               req_tvalid,
  output logic [NUM_REQ-1:0]               req_tready,

  output logic [DATA_WIDTH-1:0]            s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]            s_axis_rq_tkeep,
  output logic [3:0]                       s_axis_rq_tuser,
  output logic                             s_axis_rq_tlast,
  output logic                             s_axis_rq_tvalid,
  input  logic                             s_axis_rq_tready,

  input  logic                             np_done,
  output logic [7:0]                       np_outstanding,
  output logic [NUM_REQ-1:0]               grant
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so rr_ptr + offset cannot wrap before the modulo step.
  localparam int unsigned SumW = IdxW + 1;

  localparam logic [7:0]      MaxNp   = 8'(MAX_NP);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [SumW-1:0] NumReqS = SumW'(NUM_REQ);

  typedef enum logic [0:0] {
    StIdle,
    StPass
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]          np_cnt_q, np_cnt_d;
  logic                first_beat_q, first_beat_d;

  logic [NUM_REQ-1:0]  head_np;
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic [SumW-1:0]     cand_sum;
  logic [IdxW-1:0]     cand;
  logic                beat_acc;
  logic                np_inc;
  logic                np_dec;

  // Reads (fmt bit 30 clear), I/O writes and Cfg writes are non-posted.
  function automatic logic is_np(input logic fmt_b30, input logic [4:0] tlp_type);
    logic io_cfg_wr;
    io_cfg_wr = (tlp_type == 5'b00010) || (tlp_type == 5'b00100) || (tlp_type == 5'b00101);
    return !fmt_b30 || io_cfg_wr;
  endfunction

  // ---------------------------------------------------------------------------
  // Head-packet classification and eligibility
  // ---------------------------------------------------------------------------
  // In IDLE every presented beat is the first beat of that requester's next
  // packet, so tdata[31:24] is the header byte of the candidate packet.
  always_comb begin
    head_np  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head_np[i]  = is_np(req_tdata[i*DATA_WIDTH + 30], req_tdata[i*DATA_WIDTH + 24 +: 5]);
      eligible[i] = req_tvalid[i] && (!head_np[i] || (np_cnt_q < MaxNp));
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible index at or after rr_ptr, modulo NUM_REQ
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (cand_sum >= NumReqS) begin
        cand_sum = cand_sum - NumReqS;
      end
      cand = cand_sum[IdxW-1:0];
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: combinational pass-through of the granted requester
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axis_rq_tdata  = '0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tuser  = '0;
    s_axis_rq_tlast  = 1'b0;
    s_axis_rq_tvalid = 1'b0;
    req_tready       = '0;
    if (state_q == StPass) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          s_axis_rq_tdata  = req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_axis_rq_tkeep  = req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          s_axis_rq_tuser  = req_tuser[i*4 +: 4];
          s_axis_rq_tlast  = req_tlast[i];
          s_axis_rq_tvalid = req_tvalid[i];
          req_tready[i]    = s_axis_rq_tready;
        end
      end
    end
  end

  assign beat_acc = s_axis_rq_tvalid && s_axis_rq_tready;

  // ---------------------------------------------------------------------------
  // Arbitration state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    first_beat_d = first_beat_q;
    np_inc       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StPass;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          first_beat_d      = 1'b1;
        end
      end

      StPass: begin
        if (beat_acc) begin
          first_beat_d = 1'b0;
          // The credit is taken when the first beat actually leaves.
          np_inc       = first_beat_q && head_np[gidx_q];
          if (s_axis_rq_tlast) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // NP credit counter
  // ---------------------------------------------------------------------------
  // A completion in the same cycle as a new NP launch cancels out. A completion
  // with nothing outstanding is dropped.
  always_comb begin
    np_dec   = np_done && (np_cnt_q != 8'd0);
    np_cnt_d = np_cnt_q;
    if (np_inc && !np_dec) begin
      if (np_cnt_q < MaxNp) begin
        np_cnt_d = np_cnt_q + 8'd1;
      end
    end else if (np_dec && !np_inc) begin
      np_cnt_d = np_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      np_cnt_q     <= '0;
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      np_cnt_q     <= np_cnt_d;
      first_beat_q <= first_beat_d;
    end
  end

  assign grant          = grant_q;
  assign np_outstanding = np_cnt_q;

endmodule
